// File: rtl/dmem_requester_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_requester_if
//  Description : Signal bundle for the data-memory requester: load/store
//                request channel, response channel and the DMEM bus.
//                master = the requester (DMEM initiator, request sink)
//                slave  = its environment (pipeline stage and DMEM)
//                Also provides the shared mem_op encoding macros.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef MEM_OP_BITS
`define MEM_OP_BITS  2
`define MEM_OP_NOP   2'd0
`define MEM_OP_READ  2'd1
`define MEM_OP_WRITE 2'd2
`endif

interface dmem_requester_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [1:0]              req_size;
    logic                    req_unsigned;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic                    resp_err;
    logic [ADDR_WIDTH-1:0]   mem_address;
    logic [DATA_WIDTH-1:0]   mem_write_data;
    logic [`MEM_OP_BITS-1:0] mem_op;
    logic [DATA_WIDTH-1:0]   mem_read_data;

    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_data, resp_err,
        input  resp_ready,
        output mem_address, mem_write_data, mem_op,
        input  mem_read_data
    );

    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_data, resp_err,
        output resp_ready,
        input  mem_address, mem_write_data, mem_op,
        output mem_read_data
    );
endinterface

`default_nettype wire

// File: rtl/dmem_requester.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_requester
//  Description : Data-memory initiator. Accepts load/store requests, issues
//                word-aligned DMEM accesses (read-modify-write for byte and
//                halfword stores) and returns extended load data.
//                Optional macro DMEM_MISALIGN_TRAP_EN: misaligned halfword /
//                word requests skip memory and respond with resp_err = 1.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef MEM_OP_BITS
`define MEM_OP_BITS  2
`define MEM_OP_NOP   2'd0
`define MEM_OP_READ  2'd1
`define MEM_OP_WRITE 2'd2
`endif

module dmem_requester #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    dmem_requester_if.master bus,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_RMW_RD = 3'd2,
        S_RMW_WR = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                  state_q;
    logic                    write_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [1:0]              lane_q;
    logic [15:0]             wdata_q;

    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic                    resp_err_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [`MEM_OP_BITS-1:0] mem_op_q;

    logic                    w_sub_store;
    logic                    w_misalign;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load_ext;
    logic [DATA_WIDTH-1:0]   w_merge;

    // Classify the incoming request: sub-word stores need a read-modify-write
    always_comb begin
        w_sub_store = bus.req_write && !bus.req_size[1];
`ifdef DMEM_MISALIGN_TRAP_EN
        w_misalign  = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
        w_misalign  = 1'b0;
`endif
    end

    // Select the addressed lane of the read word and extend it for loads
    always_comb begin
        w_byte = bus.mem_read_data[7:0];
        case (lane_q)
            2'd1:    w_byte = bus.mem_read_data[15:8];
            2'd2:    w_byte = bus.mem_read_data[23:16];
            2'd3:    w_byte = bus.mem_read_data[31:24];
            default: w_byte = bus.mem_read_data[7:0];
        endcase
        w_half = lane_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
        case (size_q)
            2'b00:   w_load_ext = {{24{~uns_q & w_byte[7]}}, w_byte};
            2'b01:   w_load_ext = {{16{~uns_q & w_half[15]}}, w_half};
            default: w_load_ext = bus.mem_read_data;
        endcase
    end

    // Replace the target lane of the read word with the store data
    always_comb begin
        w_merge = bus.mem_read_data;
        if (size_q == 2'b01) begin
            if (lane_q[1]) w_merge[31:16] = wdata_q;
            else           w_merge[15:0]  = wdata_q;
        end else begin
            case (lane_q)
                2'd0:    w_merge[7:0]   = wdata_q[7:0];
                2'd1:    w_merge[15:8]  = wdata_q[7:0];
                2'd2:    w_merge[23:16] = wdata_q[7:0];
                default: w_merge[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // Sequencer; every output is registered so the DMEM bus never glitches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            resp_data_q  <= '0;
            mem_wdata_q  <= '0;
            mem_addr_q   <= '0;
            mem_op_q     <= `MEM_OP_NOP;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        write_q     <= bus.req_write;
                        size_q      <= bus.req_size;
                        uns_q       <= bus.req_unsigned;
                        lane_q      <= bus.req_addr[1:0];
                        wdata_q     <= bus.req_wdata[15:0];
                        mem_addr_q  <= {2'b00, bus.req_addr[ADDR_WIDTH-1:2]};
                        resp_data_q <= '0;
                        resp_err_q  <= 1'b0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (w_misalign) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (w_sub_store) begin
                            mem_op_q <= `MEM_OP_READ;
                            state_q  <= S_RMW_RD;
                        end else begin
                            mem_op_q <= bus.req_write ? `MEM_OP_WRITE : `MEM_OP_READ;
                            if (bus.req_write) mem_wdata_q <= bus.req_wdata;
                            state_q  <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!write_q) resp_data_q <= w_load_ext;
                    mem_op_q     <= `MEM_OP_NOP;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RMW_RD: begin
                    mem_wdata_q <= w_merge;
                    mem_op_q    <= `MEM_OP_WRITE;
                    state_q     <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    mem_op_q     <= `MEM_OP_NOP;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    mem_op_q     <= `MEM_OP_NOP;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.mem_address    = mem_addr_q;
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.mem_op         = mem_op_q;
    assign busy               = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_requester
//  Description : Directed self-checking bench for dmem_requester with a
//                64-word behavioural DMEM (combinational read).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_dmem_requester;

    logic clk;
    logic reset_n;
    logic busy;

    dmem_requester_if bus ();

    dmem_requester u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master),
        .busy    (busy)
    );

    logic [31:0] mem [0:63];
    int          wr_cnt;
    int          rd_cnt;
    int          n_vec;
    int          n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_read_data = mem[bus.mem_address[5:0]];

    // Behavioural DMEM plus access counters
    always @(posedge clk) begin
        if (bus.mem_op == `MEM_OP_WRITE) begin
            mem[bus.mem_address[5:0]] <= bus.mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.mem_op == `MEM_OP_READ) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One request; lat = k where resp_valid is first seen at edge N+k
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int stall, input logic [31:0] exp_data,
                          output int lat, output logic [31:0] data, output logic err);
        int guard;
        @(negedge clk);
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("req_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 20) check("resp_valid_timeout", 32'd0, 32'd1);
        data = bus.resp_data;
        err  = bus.resp_err;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("stall_resp_data", bus.resp_data, exp_data);
            check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
            check("stall_mem_op", {30'd0, bus.mem_op}, {30'd0, `MEM_OP_NOP});
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        if (stall > 0) check("handoff_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    endtask

    int          lat;
    logic [31:0] data;
    logic        err;
    int          wr0;
    int          rd0;

    initial begin
        n_vec = 0; n_err = 0; wr_cnt = 0; rd_cnt = 0;
        reset_n          = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        check("rst_mem_op", {30'd0, bus.mem_op}, {30'd0, `MEM_OP_NOP});
        check("rst_mem_address", bus.mem_address, 32'd0);
        check("rst_mem_wdata", bus.mem_write_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Word store then word load at 0x10
        wr0 = wr_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 32'd0, lat, data, err);
        check("wst_latency", lat, 32'd2);
        check("wst_resp_data", data, 32'd0);
        check("wst_mem_address", bus.mem_address, 32'h4);
        check("wst_mem_word", mem[4], 32'hDEADBEEF);
        check("wst_writes", wr_cnt - wr0, 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 32'd0, lat, data, err);
        check("wld_latency", lat, 32'd2);
        check("wld_data", data, 32'hDEADBEEF);
        check("wld_err", {31'd0, err}, 32'd0);

        // Byte store into word 0x20 via read-modify-write
        do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h11223344, 0, 32'd0, lat, data, err);
        check("w11_mem_word", mem[8], 32'h11223344);
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, 0, 32'd0, lat, data, err);
        check("bst_latency", lat, 32'd3);
        check("bst_mem_word", mem[8], 32'h11AA3344);
        check("bst_reads", rd_cnt - rd0, 32'd1);
        check("bst_writes", wr_cnt - wr0, 32'd1);

        // Sub-word loads of 0x80FF7F01
        do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF7F01, 0, 32'd0, lat, data, err);
        do_req(1'b0, 2'b00, 1'b0, 32'h33, 32'h0, 0, 32'd0, lat, data, err);
        check("lb_off3", data, 32'hFFFFFF80);
        do_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 0, 32'd0, lat, data, err);
        check("lhu_off2", data, 32'h000080FF);
        do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 0, 32'd0, lat, data, err);
        check("lh_off2", data, 32'hFFFF80FF);
        do_req(1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 0, 32'd0, lat, data, err);
        check("lbu_off1", data, 32'h0000007F);
        do_req(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 0, 32'd0, lat, data, err);
        check("lb_off0", data, 32'h00000001);

        // Halfword store to upper lane, upper wdata bits must be ignored
        do_req(1'b1, 2'b01, 1'b0, 32'h32, 32'h1234BEEF, 0, 32'd0, lat, data, err);
        check("hst_latency", lat, 32'd3);
        check("hst_mem_word", mem[12], 32'hBEEF7F01);

        // Response back-pressure for five cycles
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, 32'hDEADBEEF, lat, data, err);
        check("stall_first_data", data, 32'hDEADBEEF);
        check("after_handoff_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Reset asserted while in RMW_RD
        do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h55667788, 0, 32'd0, lat, data, err);
        @(negedge clk);
        bus.req_write = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h41; bus.req_wdata = 32'h99; bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rmw_rd_op", {30'd0, bus.mem_op}, {30'd0, `MEM_OP_READ});
        wr0 = wr_cnt;
        reset_n = 1'b0;
        #1;
        check("arst_mem_op", {30'd0, bus.mem_op}, {30'd0, `MEM_OP_NOP});
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_mem_word", mem[16], 32'h55667788);
        check("arst_writes", wr_cnt - wr0, 32'd0);
        check("arst_idle_busy", {31'd0, busy}, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 32'd0, lat, data, err);
        check("arst_reload", data, 32'h55667788);

        // Misaligned halfword load and word store
        wr0 = wr_cnt;
        do_req(1'b0, 2'b01, 1'b0, 32'h33, 32'h0, 0, 32'd0, lat, data, err);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis_lh_latency", lat, 32'd1);
        check("mis_lh_err", {31'd0, err}, 32'd1);
        check("mis_lh_data", data, 32'd0);
`else
        check("mis_lh_latency", lat, 32'd2);
        check("mis_lh_err", {31'd0, err}, 32'd0);
        check("mis_lh_data", data, 32'hFFFFBEEF);
`endif
        do_req(1'b1, 2'b10, 1'b0, 32'h13, 32'h12345678, 0, 32'd0, lat, data, err);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis_sw_latency", lat, 32'd1);
        check("mis_sw_err", {31'd0, err}, 32'd1);
        check("mis_sw_mem_word", mem[4], 32'hDEADBEEF);
        check("mis_sw_writes", wr_cnt - wr0, 32'd0);
`else
        check("mis_sw_latency", lat, 32'd2);
        check("mis_sw_err", {31'd0, err}, 32'd0);
        check("mis_sw_mem_address", bus.mem_address, 32'h4);
        check("mis_sw_mem_word", mem[4], 32'h12345678);
        check("mis_sw_writes", wr_cnt - wr0, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
